tx_gearbox: RTL and testbench

TX_GEARBOX -- requirements
Module: tx_gearbox

---
 rtl/teng_phy_pkg.sv | 15 +
 rtl/tx_gearbox_if.sv | 23 ++
 rtl/tx_gearbox_buf.sv | 42 ++++
 rtl/tx_gearbox.sv | 116 +++++++++++
 tb/tb_tx_gearbox.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/teng_phy_pkg.sv
// Shared 10GBASE-R PHY constants and the 66-bit block payload type.
package teng_phy_pkg;

    localparam int unsigned BLK_W     = 66;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned GB_BUF_W  = 192;
    localparam int unsigned GB_FILL_W = 8;

    // Scrambled block: payload on top, sync header in the two LSBs (bit 0 sent first)
    typedef struct packed {
        logic [63:0] payload;
        logic [1:0]  hdr;
    } blk_t;

endpackage

// File: rtl/tx_gearbox_if.sv
// Block-in / word-out bus of the TX gearbox, plus its error pulses.
interface tx_gearbox_if;
    import teng_phy_pkg::*;

    blk_t              data_i;
    logic              data_vld_i;
    logic              data_rdy_o;
    logic [WORD_W-1:0] data_o;
    logic              data_vld_o;
    logic              overflow_o;
    logic              underflow_o;

    modport master (
        output data_i, data_vld_i,
        input  data_rdy_o, data_o, data_vld_o, overflow_o, underflow_o
    );

    modport slave (
        input  data_i, data_vld_i,
        output data_rdy_o, data_o, data_vld_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/tx_gearbox_buf.sv
// 192-bit gearbox buffer (bit 0 oldest): 32-bit drain shift plus a 66-bit
// insert at a variable offset into the post-shift image, both in one cycle.
module tx_gearbox_buf
    import teng_phy_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 shift_i,
    input  logic                 wr_en_i,
    input  logic [GB_FILL_W-1:0] wr_pos_i,
    input  logic [BLK_W-1:0]     wr_data_i,
    output logic [WORD_W-1:0]    head_o
);

    localparam logic [GB_BUF_W-1:0] BLK_MASK = GB_BUF_W'({BLK_W{1'b1}});

    logic [GB_BUF_W-1:0] buf_q;
    logic [GB_BUF_W-1:0] buf_d;
    logic [GB_BUF_W-1:0] shifted;

    // Shift out the oldest word, then overwrite the block field above the live bits
    always_comb begin
        shifted = shift_i ? (buf_q >> WORD_W) : buf_q;
        buf_d   = shifted;
        if (wr_en_i) begin
            buf_d = (shifted & ~(BLK_MASK << wr_pos_i))
                  | (GB_BUF_W'(wr_data_i) << wr_pos_i);
        end
    end

    // Buffer register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign head_o = buf_q[WORD_W-1:0];

endmodule

// File: rtl/tx_gearbox.sv
// 66b -> 32b TX gearbox. Emits a word whenever 32 bits are buffered and
// requests a block one cycle ahead of need, counting the block in flight.
// Optional macro TX_GEARBOX_ERR_EN compiles in overflow/underflow detection;
// without it overflow_o/underflow_o are tied low.
module tx_gearbox
    import teng_phy_pkg::*;
#(
    parameter int unsigned REQ_THRESH = 96
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    tx_gearbox_if.slave gb
);

    localparam int unsigned SUM_W = GB_FILL_W + 2;

    logic [GB_FILL_W-1:0] fill_q;
    logic [GB_FILL_W-1:0] fill_d;
    logic                 r_q;
    logic                 r_d;
    logic [WORD_W-1:0]    data_q;
    logic [WORD_W-1:0]    data_d;
    logic                 vld_q;
    logic                 vld_d;

    logic                 out_c;
    logic                 wr_en_c;
    logic [GB_FILL_W-1:0] wr_pos_c;
    logic [SUM_W-1:0]     fill_nxt_c;
    logic [WORD_W-1:0]    head;

`ifdef TX_GEARBOX_ERR_EN
    logic ovf_d;
    logic ovf_q;
    logic unf_d;
    logic unf_q;
    logic first_d;
    logic first_q;
`endif

    tx_gearbox_buf u_buf (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .shift_i   (out_c),
        .wr_en_i   (wr_en_c),
        .wr_pos_i  (wr_pos_c),
        .wr_data_i (gb.data_i),
        .head_o    (head)
    );

    // Word emit decision, insert position, next fill level and next request
    always_comb begin
        out_c    = (fill_q >= GB_FILL_W'(WORD_W));
        wr_pos_c = out_c ? (fill_q - GB_FILL_W'(WORD_W)) : fill_q;
        wr_en_c  = gb.data_vld_i;
`ifdef TX_GEARBOX_ERR_EN
        ovf_d = 1'b0;
        if (gb.data_vld_i && ((SUM_W'(wr_pos_c) + SUM_W'(BLK_W)) > SUM_W'(GB_BUF_W))) begin
            wr_en_c = 1'b0;
            ovf_d   = 1'b1;
        end
`endif
        fill_nxt_c = SUM_W'(wr_pos_c) + (wr_en_c ? SUM_W'(BLK_W) : SUM_W'(0));
        fill_d     = GB_FILL_W'(fill_nxt_c);
        r_d        = (fill_nxt_c + (r_q ? SUM_W'(BLK_W) : SUM_W'(0))) < SUM_W'(REQ_THRESH);
        data_d     = out_c ? head : data_q;
        vld_d      = out_c;
    end

    // Control and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fill_q <= '0;
            r_q    <= 1'b0;
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            r_q    <= r_d;
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign gb.data_rdy_o = r_q;
    assign gb.data_o     = data_q;
    assign gb.data_vld_o = vld_q;

`ifdef TX_GEARBOX_ERR_EN
    // Underflow is armed once the first word has left the gearbox
    always_comb begin
        unf_d   = first_q && !out_c;
        first_d = first_q || out_c;
    end

    // Error pulse registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            first_q <= first_d;
        end
    end

    assign gb.overflow_o  = ovf_q;
    assign gb.underflow_o = unf_q;
`else
    assign gb.overflow_o  = 1'b0;
    assign gb.underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_tx_gearbox.sv
// Bench for tx_gearbox: bit-queue reference model, randomized block payloads,
// directed phases for latency, steady streaming, starvation, overflow and reset.
module tb_tx_gearbox;
    import teng_phy_pkg::*;

    localparam int unsigned THRESH = 96;
`ifdef TX_GEARBOX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    tx_gearbox_if gb_if ();

    tx_gearbox #(.REQ_THRESH(THRESH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .gb      (gb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: serial bit queue (front = next bit on the line)
    bit          mq[$];
    logic [31:0] m_word;
    logic        m_vld;
    logic        m_r;
    logic        m_first;
    logic        m_ovf;
    logic        m_unf;

    function automatic logic [65:0] rnd_blk();
        return {$urandom(), $urandom(), 2'($urandom())};
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_word  = '0;
        m_vld   = 1'b0;
        m_r     = 1'b0;
        m_first = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".data_vld_o"},  66'(gb_if.data_vld_o),  66'(m_vld));
        chk({tag, ".data_o"},      66'(gb_if.data_o),      66'(m_word));
        chk({tag, ".data_rdy_o"},  66'(gb_if.data_rdy_o),  66'(m_r));
        chk({tag, ".overflow_o"},  66'(gb_if.overflow_o),  66'(m_ovf));
        chk({tag, ".underflow_o"}, 66'(gb_if.underflow_o), 66'(m_unf));
    endtask

    // One clock: drive inputs, advance model, then compare 1 time unit after the edge
    task automatic cycle(input logic vld, input logic [65:0] din);
        logic out;
        gb_if.data_vld_i = vld;
        gb_if.data_i     = din;
        out   = (mq.size() >= 32);
        m_vld = out;
        if (out) begin
            for (int i = 0; i < 32; i++) m_word[i] = mq.pop_front();
        end
        m_unf   = ERR_EN && m_first && !out;
        m_first = m_first || out;
        m_ovf   = 1'b0;
        if (vld) begin
            if (ERR_EN && (mq.size() + 66 > 192)) m_ovf = 1'b1;
            else for (int i = 0; i < 66; i++) mq.push_back(din[i]);
        end
        m_r = ((mq.size() + (m_r ? 66 : 0)) < THRESH);
        @(posedge clk);
        #1;
        chk_outputs("cyc");
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_outputs(tag);
        #2 rst_n = 1'b1;
    endtask

    logic [65:0] blk;
    logic        v;
    logic        pend;
    int          acc;
    int          gaps;
    int          gaps_late;
    int          skip;
    int          unfc;
    int          ovfc;

    initial begin
        rst_n            = 1'b0;
        gb_if.data_vld_i = 1'b0;
        gb_if.data_i     = '0;
        model_reset();
        #12;
        chk_outputs("reset");
        rst_n = 1'b1;

        // Single known block: latency, bit order, residual fill
        cycle(1'b0, '0);
        chk("rdy_after_release", 66'(gb_if.data_rdy_o), 66'(1));
        blk = {64'h0123456789ABCDEF, 2'b10};
        cycle(1'b1, blk);
        chk("blk1_no_word_yet", 66'(gb_if.data_vld_o), 66'(0));
        cycle(1'b0, '0);
        chk("blk1_w0", 66'(gb_if.data_o), 66'(32'h26AF37BE));
        cycle(1'b0, '0);
        chk("blk1_w1", 66'(gb_if.data_o), 66'(32'h048D159E));
        cycle(1'b0, '0);
        chk("blk1_vld_drop", 66'(gb_if.data_vld_o), 66'(0));
        chk("blk1_fill", 66'(dut.fill_q), 66'(2));

        // Compliant responder: block one cycle after each request
        do_reset("reset_stream");
        pend = 1'b0;
        acc  = 0;
        gaps = 0;
        for (int c = 0; c < 760; c++) begin
            v = pend;
            cycle(v, rnd_blk());
            if (c >= 100) begin
                if (v) acc++;
                if (gb_if.data_vld_o !== 1'b1) gaps++;
            end
            pend = gb_if.data_rdy_o;
        end
        chk("stream_gaps", 66'(gaps), 66'(0));
        chk("stream_blocks", 66'(acc), 66'(320));

        // Starvation: ignore three request cycles, then resume
        gaps      = 0;
        gaps_late = 0;
        unfc      = 0;
        skip      = 0;
        for (int c = 0; c < 80; c++) begin
            if (c == 10) skip = 3;
            v = pend;
            if (pend && skip > 0) begin
                v = 1'b0;
                skip--;
            end
            cycle(v, rnd_blk());
            if (gb_if.data_vld_o !== 1'b1) begin
                gaps++;
                if (c >= 60) gaps_late++;
            end
            if (gb_if.underflow_o === 1'b1) unfc++;
            pend = gb_if.data_rdy_o;
        end
        chk("starve_gap_seen", 66'(gaps > 0), 66'(1));
        chk("starve_unf_seen", 66'(unfc > 0), 66'(ERR_EN));
        chk("starve_recovered", 66'(gaps_late), 66'(0));

`ifdef TX_GEARBOX_ERR_EN
        // Blocks every cycle regardless of requests: overflow drops
        ovfc = 0;
        for (int c = 0; c < 24; c++) begin
            cycle(1'b1, rnd_blk());
            if (gb_if.overflow_o === 1'b1) ovfc++;
        end
        chk("flood_ovf_seen", 66'(ovfc > 0), 66'(1));
        for (int c = 0; c < 10; c++) cycle(1'b0, '0);
`endif

        // Asynchronous reset with 34 bits buffered
        do_reset("reset_mid");
        cycle(1'b0, '0);
        cycle(1'b1, rnd_blk());
        cycle(1'b0, '0);
        chk("mid_fill34", 66'(dut.fill_q), 66'(34));
        chk("mid_vld_before", 66'(gb_if.data_vld_o), 66'(1));
        do_reset("reset_async");
        cycle(1'b0, '0);
        blk = rnd_blk();
        cycle(1'b1, blk);
        cycle(1'b0, '0);
        chk("post_reset_w0", 66'(gb_if.data_o), 66'(blk[31:0]));
        cycle(1'b0, '0);
        chk("post_reset_w1", 66'(gb_if.data_o), 66'(blk[63:32]));
        cycle(1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
